// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int ARB_N     = 4;
  localparam int ARB_PTR_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index -> one-hot grant code.
  function automatic logic [ARB_N-1:0] onehot(input logic [ARB_PTR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // One-hot grant code -> index of its set bit (0 for an all-zero code).
  function automatic logic [ARB_PTR_W-1:0] onehot_idx(input logic [ARB_N-1:0] vec);
    onehot_idx = '0;
    for (int i = 0; i < ARB_N; i++) begin
      if (vec[i]) onehot_idx = ARB_PTR_W'(i);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_4_pick.sv
// rr_pick: combinational rotate-priority search. Scans req starting at ptr
// and wrapping modulo N; reports the first set bit found.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int PTR_W = ARB_PTR_W
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_valid
);

  logic [PTR_W-1:0] cand;

  // First requester at or after ptr, in circular order.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = PTR_W'((int'(ptr) + i) % N);
      if (!win_valid && req[cand]) begin
        win_idx   = cand;
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: registered round-robin arbiter over 4 requesters.
// gnt is one-hot or zero and always passes through a zero cycle between
// owners. Optional hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = 16,
  parameter int PTR_W    = ARB_PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic         busy,
  output logic         timeout
);

  if (N != 4 || PTR_W != 2 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_arbiter_4: N must be 4, PTR_W 2, MAX_HOLD >= 1");
  end

  state_t           state, state_next;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic             win_valid;
  logic [PTR_W-1:0] owner_idx;
  logic             release_normal;
  logic             hold_expired;
  logic             release_go;

  rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  assign owner_idx      = onehot_idx(gnt);
  assign release_normal = done || !req[owner_idx];
  assign release_go     = release_normal || hold_expired;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Count cycles of the current grant; zero on every IDLE so it enters GRANT cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                hold_cnt <= '0;
    else if (state == IDLE) hold_cnt <= '0;
    else                    hold_cnt <= hold_cnt + 1'b1;
  end

  // The MAX_HOLD-th grant cycle is the last one.
  assign hold_expired = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Flag the release cycle only when the timer, not the owner, ended the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= hold_expired && !release_normal;
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: arbitrate in IDLE, hold in GRANT until released.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_valid)  state_next = GRANT;
      GRANT:   if (release_go) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant and pointer registers; the pointer moves only on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt <= '0;
      ptr <= '0;
    end else begin
      case (state)
        IDLE: if (win_valid) gnt <= onehot(win_idx);
        GRANT: if (release_go) begin
          gnt <= '0;
          ptr <= owner_idx + 1'b1;
        end
        default: gnt <= '0;
      endcase
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    busy      = (state == GRANT);
    gnt_valid = |gnt;
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: a cycle model compared every negedge
// plus directed scenarios with literal expectations.
// Define ARB_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
module tb_rr_arbiter_4;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic [N-1:0] req  = 4'b1111;
  logic         done = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         busy;
  logic         timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter_4 #(.N(N), .MAX_HOLD(MAX_HOLD), .PTR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is -1 when nobody holds the grant.
  int m_owner   = -1;
  int m_ptr     = 0;
  int m_held    = 0;
  bit m_timeout = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_timeout = 1'b0;
    end else begin
      m_timeout = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_held  = 0;
          end
        end
      end else begin
        bit normal, forced;
        m_held++;
        normal = done || !req[m_owner];
`ifdef ARB_TIMEOUT_EN
        forced = (m_held >= MAX_HOLD);
`else
        forced = 1'b0;
`endif
        if (normal || forced) begin
          m_ptr     = (m_owner + 1) % N;
          m_owner   = -1;
          m_timeout = forced && !normal;
        end
      end
    end
  end

  function automatic logic [N-1:0] model_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  // Compare DUT against model away from the active edge.
  always @(negedge clk) begin
    check("cyc_gnt",       gnt,       model_gnt());
    check("cyc_gnt_valid", gnt_valid, m_owner >= 0);
    check("cyc_busy",      busy,      m_owner >= 0);
    check("cyc_timeout",   timeout,   m_timeout);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  logic [N-1:0] seq3 [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                             4'b0000, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    // 1: async reset with requests pending, before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_gnt",   gnt,       4'b0000);
    check("rst_valid", gnt_valid, 1'b0);
    check("rst_busy",  busy,      1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_gnt",  gnt,  4'b0000);
    check("rst_hold_busy", busy, 1'b0);
    #1 rst = 1'b0; req = 4'b0000;

    // 2: single grant, held until done, pointer then at 1.
    req = 4'b0001;
    tick();
    check("t2_gnt",   gnt,       4'b0001);
    check("t2_valid", gnt_valid, 1'b1);
    check("t2_busy",  busy,      1'b1);
    tick(); tick();
    check("t2_held", gnt, 4'b0001);
    done = 1'b1;
    tick();
    check("t2_release", gnt, 4'b0000);
    done = 1'b0; req = 4'b0011;
    tick();
    check("t2_ptr1", gnt, 4'b0010);
    req = 4'b0000;
    tick();
    check("t2_drop_release", gnt, 4'b0000);

    // 3: full rotation with all requesting and done held high.
    rst = 1'b1; #1 rst = 1'b0;
    done = 1'b1; req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("t3_seq%0d", i), gnt, seq3[i]);
    end
    req = 4'b0100;
    tick();
    check("t3_release", gnt, 4'b0000);
    done = 1'b0;
    tick();
    check("t3_win2", gnt, 4'b0100);

    // 4: release owner 2 (ptr -> 3) with req=0101, search wraps to 0, then 2.
    req = 4'b0101; done = 1'b1;
    tick();
    check("t4_bubble", gnt, 4'b0000);
    done = 1'b0;
    tick();
    check("t4_wrap", gnt, 4'b0001);
    done = 1'b1;
    tick();
    check("t4_bubble2", gnt, 4'b0000);
    done = 1'b0;
    tick();
    check("t4_next", gnt, 4'b0100);

    // 5: reset mid-grant clears gnt without a clock edge.
    rst = 1'b1;
    #1;
    check("t5_gnt",   gnt,  4'b0000);
    check("t5_busy",  busy, 1'b0);
    rst = 1'b0; req = 4'b0100;
    tick();
    check("t5_regrant", gnt, 4'b0100);

    // 6: long hold with done low.
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    check("t6_gnt", gnt, 4'b0010);
`ifdef ARB_TIMEOUT_EN
    tick(); tick(); tick();
    check("t6_hold4", gnt, 4'b0010);
    tick();
    check("t6_forced_gnt", gnt,     4'b0000);
    check("t6_timeout",    timeout, 1'b1);
    tick();
    check("t6_timeout_pulse", timeout, 1'b0);
    check("t6_regrant",       gnt,     4'b0010);
`else
    repeat (120) tick();
    check("t6_long_gnt", gnt,     4'b0010);
    check("t6_no_tmo",   timeout, 1'b0);
`endif

    // Other requesters changing during a grant are ignored.
    req = 4'b1011;
    tick();
    check("t7_ignore_others", gnt, 4'b0010);
    // Release together with new requests: release wins, bubble first.
    done = 1'b1; req = 4'b1111;
    tick();
    check("t7_bubble", gnt, 4'b0000);
    // done during IDLE is ignored; ptr is 2 now.
    tick();
    check("t7_done_idle", gnt, 4'b0100);
    done = 1'b0; req = 4'b0000;
    tick();
    check("t7_owner_drop", gnt, 4'b0000);
    tick();
    check("t7_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
